// File: rtl/mem_arb_defs.sv
// Shared definitions for the CPU memory-port arbiter: FSM and owner encodings,
// alignment mask and counter widths.
package mem_arb_defs;

    localparam int          LAT_W     = 3;
    localparam logic [31:0] WORD_MASK = 32'h0000_0003;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RESP   = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    function automatic int starve_w(input int max_cnt);
        return (max_cnt < 2) ? 1 : $clog2(max_cnt + 1);
    endfunction

endpackage

// File: rtl/arb_prio_sel.sv
// Priority select between fetch and data: data wins unless fetch has been
// passed over STARVE_MAX times in a row.
module arb_prio_sel
    import mem_arb_defs::*;
#(
    parameter int STARVE_MAX = 2
) (
    input  logic                            i_if_req,
    input  logic                            i_d_req,
    input  logic [starve_w(STARVE_MAX)-1:0] i_starve_cnt,
    output logic                            o_sel_if,
    output logic                            o_sel_d
);

    localparam int CNT_W = starve_w(STARVE_MAX);

    logic w_starved;

    assign w_starved = (i_starve_cnt == CNT_W'(STARVE_MAX));
    assign o_sel_if  = i_if_req & (~i_d_req | w_starved);
    assign o_sel_d   = i_d_req & ~o_sel_if;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one word-wide memory port between instruction fetch and load/store,
// one transaction at a time, reporting misaligned accesses without touching memory.
module mem_port_arbiter
    import mem_arb_defs::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 2
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int               SW       = starve_w(STARVE_MAX);
    localparam logic [LAT_W-1:0] LAT_LOAD = (MEM_LAT > 1) ? LAT_W'(MEM_LAT - 2) : '0;

    state_t           r_state;
    state_t           w_state_nxt;
    owner_t           r_owner;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic             r_we;
    logic [SW-1:0]    r_starve;
    logic [LAT_W-1:0] r_lat_cnt;

    logic             w_sel_if;
    logic             w_sel_d;
    logic             w_gnt_if;
    logic             w_gnt_d;
    logic [31:0]      w_req_addr;
    logic             w_misaligned;
    logic             w_resp;
    logic             w_err;
    logic [31:0]      w_rdata;

    arb_prio_sel #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .i_if_req     (if_req),
        .i_d_req      (d_req),
        .i_starve_cnt (r_starve),
        .o_sel_if     (w_sel_if),
        .o_sel_d      (w_sel_d)
    );

    // Grants are combinational and suppressed while reset is held.
    assign w_gnt_if     = clrn & (r_state == ST_IDLE) & w_sel_if;
    assign w_gnt_d      = clrn & (r_state == ST_IDLE) & w_sel_d;
    assign w_req_addr   = w_sel_d ? d_addr : if_addr;
    assign w_misaligned = |(w_req_addr & WORD_MASK);

    // NOTE: every variable written here gets its default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_gnt_if || w_gnt_d) w_state_nxt = w_misaligned ? ST_ERR : ST_ACCESS;
            ST_ACCESS: w_state_nxt = (MEM_LAT == 1) ? ST_RESP : ST_WAIT;
            ST_WAIT:   if (r_lat_cnt == '0) w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            ST_ERR:    w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state   <= ST_IDLE;
            r_starve  <= '0;
            r_lat_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_ACCESS) begin
                r_lat_cnt <= LAT_LOAD;
            end else if (r_state == ST_WAIT) begin
                r_lat_cnt <= r_lat_cnt - LAT_W'(1);
            end
            if (w_gnt_if || (r_state == ST_IDLE && !if_req)) begin
                r_starve <= '0;
            end else if (w_gnt_d && if_req && r_starve != SW'(STARVE_MAX)) begin
                r_starve <= r_starve + SW'(1);
            end
        end
    end

    // NOTE: the transaction latches carry no reset; they are only observed in states entered through a grant, which reloads them.
    always_ff @(posedge clk) begin
        if (w_gnt_if || w_gnt_d) begin
            r_owner <= w_gnt_d ? OWN_D : OWN_IF;
            r_addr  <= w_req_addr;
            r_we    <= w_gnt_d & d_we;
            r_wdata <= d_wdata;
        end
    end

    assign w_resp  = clrn & ((r_state == ST_RESP) || (r_state == ST_ERR));
    assign w_err   = (r_state == ST_ERR);
    assign w_rdata = (r_state == ST_RESP && !r_we) ? mem_rdata : '0;

    assign if_gnt    = w_gnt_if;
    assign d_gnt     = w_gnt_d;
    assign if_rvalid = w_resp & (r_owner == OWN_IF);
    assign d_rvalid  = w_resp & (r_owner == OWN_D);
    assign if_rdata  = if_rvalid ? w_rdata : '0;
    assign d_rdata   = d_rvalid ? w_rdata : '0;
    assign if_err    = if_rvalid & w_err;
    assign d_err     = d_rvalid & w_err;

    assign mem_en    = clrn & (r_state == ST_ACCESS);
    assign mem_we    = mem_en & r_we;
    assign mem_addr  = mem_en ? (r_addr & ~WORD_MASK) : '0;
    assign mem_wdata = mem_we ? r_wdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: two instances (MEM_LAT 1 and 3) each
// with a small latency-accurate memory model; a monitor pops expected responses.
module tb_mem_port_arbiter;

    typedef struct {
        int          inst;
        logic [67:0] vec;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        clrn      [2];
    logic        if_req    [2];
    logic [31:0] if_addr   [2];
    logic        if_gnt    [2];
    logic        if_rvalid [2];
    logic [31:0] if_rdata  [2];
    logic        if_err    [2];
    logic        d_req     [2];
    logic        d_we      [2];
    logic [31:0] d_addr    [2];
    logic [31:0] d_wdata   [2];
    logic        d_gnt     [2];
    logic        d_rvalid  [2];
    logic [31:0] d_rdata   [2];
    logic        d_err     [2];
    logic        mem_en    [2];
    logic        mem_we    [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   started  = 1'b0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s", name);
    endtask

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [159:0] outs(input int k);
        return {if_gnt[k], if_rvalid[k], if_rdata[k], if_err[k], d_gnt[k], d_rvalid[k],
                d_rdata[k], d_err[k], mem_en[k], mem_we[k], mem_addr[k], mem_wdata[k]};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] mem    [64];
        logic [31:0] pipe_d [LAT];
        logic        pipe_v [LAT];
        exp_t        m_e;

        mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(2)) u_dut (
            .clk       (clk),
            .clrn      (clrn[g]),
            .if_req    (if_req[g]),
            .if_addr   (if_addr[g]),
            .if_gnt    (if_gnt[g]),
            .if_rvalid (if_rvalid[g]),
            .if_rdata  (if_rdata[g]),
            .if_err    (if_err[g]),
            .d_req     (d_req[g]),
            .d_we      (d_we[g]),
            .d_addr    (d_addr[g]),
            .d_wdata   (d_wdata[g]),
            .d_gnt     (d_gnt[g]),
            .d_rvalid  (d_rvalid[g]),
            .d_rdata   (d_rdata[g]),
            .d_err     (d_err[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g])
        );

        initial begin
            for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
            mem[0]  = 32'h1111_1111;
            mem[1]  = 32'h2222_2222;
            mem[4]  = 32'h4444_4444;
            mem[29] = 32'h8c08_0048;
            for (int i = 0; i < LAT; i++) pipe_v[i] = 1'b0;
        end

        // Read data appears MEM_LAT cycles after the mem_en cycle; otherwise a junk pattern.
        always @(posedge clk) begin
            if (mem_en[g] && mem_we[g]) mem[mem_addr[g][7:2]] <= mem_wdata[g];
            pipe_v[0] <= mem_en[g] && !mem_we[g];
            pipe_d[0] <= mem[mem_addr[g][7:2]];
            for (int i = 1; i < LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
        assign mem_rdata[g] = pipe_v[LAT-1] ? pipe_d[LAT-1] : 32'hBAD0_BAD0;

        always @(negedge clk) begin
            if (started && clrn[g]) begin
                check($sformatf("u%0d gnt exclusive", g), if_gnt[g] & d_gnt[g], 0);
                if (!if_rvalid[g]) check($sformatf("u%0d if idle zero", g), {if_rdata[g], if_err[g]}, 0);
                if (!d_rvalid[g]) check($sformatf("u%0d d idle zero", g), {d_rdata[g], d_err[g]}, 0);
                if (if_rvalid[g] || d_rvalid[g]) begin
                    if (exp_q.size() == 0 || exp_q[0].inst != g) begin
                        fail_now($sformatf("u%0d unexpected rvalid at cycle %0d", g, cyc));
                    end else begin
                        m_e = exp_q.pop_front();
                        check($sformatf("u%0d response", g),
                              {if_rvalid[g], if_rdata[g], if_err[g], d_rvalid[g], d_rdata[g], d_err[g]}, m_e.vec);
                        check($sformatf("u%0d response cycle", g), cyc, m_e.cyc);
                    end
                end
            end
        end
    end

    task automatic push_exp(input int k, input bit is_d, input logic [31:0] rd, input bit err, input int at);
        exp_t e;
        e.inst = k;
        e.cyc  = at;
        e.vec  = is_d ? {1'b0, 32'h0, 1'b0, 1'b1, rd, err} : {1'b1, rd, err, 1'b0, 32'h0, 1'b0};
        exp_q.push_back(e);
    endtask

    task automatic wait_gnt(input int k, input bit is_d, output bit ok);
        int n = 0;
        @(negedge clk);
        while (!(is_d ? d_gnt[k] : if_gnt[k]) && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = is_d ? d_gnt[k] : if_gnt[k];
        if (!ok) fail_now($sformatf("u%0d %s grant timeout", k, is_d ? "d" : "if"));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            fail_now("response timeout");
            exp_q.delete();
        end
    endtask

    task automatic do_req(input int k, input bit is_d, input bit we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input bit err);
        bit ok;
        @(posedge clk); #1;
        if (is_d) begin
            d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = a; d_wdata[k] = wd;
        end else begin
            if_req[k] = 1'b1; if_addr[k] = a;
        end
        wait_gnt(k, is_d, ok);
        if (ok) push_exp(k, is_d, exp_rd, err, cyc + (err ? 1 : lat(k) + 1));
        @(posedge clk); #1;
        if_req[k] = 1'b0;
        d_req[k]  = 1'b0;
        if (!ok) return;
        @(negedge clk);
        if (err) check($sformatf("u%0d no mem_en on misaligned %0h", k, a), mem_en[k], 0);
        else check($sformatf("u%0d access cycle %0h", k, a),
                   {mem_en[k], mem_we[k], mem_addr[k], we ? mem_wdata[k] : 32'h0},
                   {1'b1, we, a, we ? wd : 32'h0});
        drain();
    endtask

    initial begin
        bit ok;
        bit exp_is_d [6];
        int t0;
        int t1;
        exp_is_d = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 2; k++) begin
            clrn[k] = 1'b0; if_req[k] = 1'b0; if_addr[k] = '0;
            d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        clrn[0] = 1'b1;
        clrn[1] = 1'b1;
        started = 1'b1;
        @(negedge clk);
        check("u0 reset outputs", outs(0), 0);
        check("u1 reset outputs", outs(1), 0);

        // Fetch-only read, MEM_LAT = 1.
        do_req(0, 1'b0, 1'b0, 32'h0000_0074, 32'h0, 32'h8c08_0048, 1'b0);

        // Store then load, MEM_LAT = 3.
        do_req(1, 1'b1, 1'b1, 32'h0000_0048, 32'h0000_000f, 32'h0, 1'b0);
        do_req(1, 1'b1, 1'b0, 32'h0000_0048, 32'h0, 32'h0000_000f, 1'b0);

        // Misaligned data and fetch.
        do_req(0, 1'b1, 1'b0, 32'h0000_004E, 32'h0, 32'h0, 1'b1);
        do_req(0, 1'b0, 1'b0, 32'h0000_0002, 32'h0, 32'h0, 1'b1);

        // Both requesters held high: D, D, IF, D, D, IF.
        @(posedge clk); #1;
        if_req[0] = 1'b1; if_addr[0] = 32'h0;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h10;
        for (int i = 0; i < 6; i++) begin
            wait_gnt(0, exp_is_d[i], ok);
            if (!ok) break;
            check($sformatf("grant order %0d", i), {if_gnt[0], d_gnt[0]}, {!exp_is_d[i], exp_is_d[i]});
            push_exp(0, exp_is_d[i], exp_is_d[i] ? 32'h4444_4444 : 32'h1111_1111, 1'b0, cyc + 2);
            @(posedge clk);
        end
        #1;
        if_req[0] = 1'b0;
        d_req[0]  = 1'b0;
        drain();

        // Reset mid-access, MEM_LAT = 3.
        @(posedge clk); #1;
        if_req[1] = 1'b1; if_addr[1] = 32'h0;
        wait_gnt(1, 1'b0, ok);
        @(posedge clk); #1;
        if_req[1] = 1'b0;
        @(posedge clk); #1;
        clrn[1] = 1'b0;
        @(posedge clk); #1;
        clrn[1] = 1'b1;
        @(negedge clk);
        check("u1 outputs after mid-access reset", outs(1), 0);
        repeat (6) @(posedge clk);
        do_req(1, 1'b0, 1'b0, 32'h0000_0074, 32'h0, 32'h8c08_0048, 1'b0);

        // Back-to-back fetch, MEM_LAT = 1.
        @(posedge clk); #1;
        if_req[0] = 1'b1; if_addr[0] = 32'h0;
        wait_gnt(0, 1'b0, ok);
        t0 = cyc;
        if (ok) push_exp(0, 1'b0, 32'h1111_1111, 1'b0, cyc + 2);
        @(posedge clk); #1;
        if_addr[0] = 32'h4;
        wait_gnt(0, 1'b0, ok);
        t1 = cyc;
        if (ok) begin
            check("back-to-back grant spacing", t1 - t0, 3);
            push_exp(0, 1'b0, 32'h2222_2222, 1'b0, cyc + 2);
        end
        @(posedge clk); #1;
        if_req[0] = 1'b0;
        drain();

        repeat (4) @(posedge clk);
        check("scoreboard empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
